class_argmax: RTL and testbench
===============================

CLASS_ARGMAX -- requirements
Module: class_argmax

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: width of signed score words.
REQ-002 SHALL have parameter NUM_CLASSES, default 4: words per frame; legal range 2 to 256.
REQ-003 SHALL have parameter CLASS_W, default $clog2(NUM_CLASSES): width of class index.
REQ-004 SHALL have port clk_i  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port valid_i  input  1  upstream score word available on data_i.
REQ-007 SHALL have port data_i  input  WORD_SIZE  signed score word from the network output layer.
REQ-008 SHALL have port yumi_o  output  1  word on data_i consumed this cycle.
REQ-009 SHALL have port valid_o  output  1  frame result available.
REQ-010 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-011 SHALL have port class_o  output  CLASS_W  index of the maximum score in the frame.
REQ-012 SHALL have port max_o  output  WORD_SIZE  signed maximum score.
REQ-013 SHALL have port frame_cnt_o  output  16  count of completed frames (result handshakes).

Function
REQ-014 SHALL implement two states: COLLECT (accept scores) and DONE (hold result).
REQ-015 yumi_o SHALL equal valid_i AND state==COLLECT AND NOT reset_i; it is combinational from valid_i, and a word transfers on each cycle with yumi_o=1.
REQ-016 SHALL keep index counter idx_r (0..NUM_CLASSES-1), incremented on each transfer, with no other modification except reset or frame restart.
REQ-017 On a transfer with idx_r==0, max_r SHALL load data_i and class_r SHALL load 0 unconditionally.
REQ-018 On a transfer with idx_r>0, max_r/class_r SHALL load data_i/idx_r only if data_i > max_r (signed, strict); ties keep the lower index.
REQ-019 A transfer with idx_r==NUM_CLASSES-1 SHALL move the state to DONE and clear idx_r; valid_o SHALL rise on the next cycle (one cycle latency from the last yumi_o).
REQ-020 valid_o SHALL equal state==DONE; class_o/max_o SHALL be stable while valid_o=1.
REQ-021 In DONE, yumi_o SHALL be 0 regardless of valid_i; the upstream data is held, not dropped.
REQ-022 On valid_o AND ready_i, the state SHALL go to COLLECT, and frame_cnt_o SHALL increment, wrapping 0xFFFF->0; the first word of the next frame can transfer on the following cycle.
REQ-023 Cycles with valid_i=0 in COLLECT SHALL leave all state unchanged (gaps are allowed anywhere in a frame).
REQ-024 ready_i SHALL be ignored while valid_o=0.

Reset
REQ-025 While reset_i=1: state=COLLECT, idx_r=0, valid_o=0, yumi_o=0, class_o=0, max_o=0, frame_cnt_o=0.
REQ-026 A reset asserted mid-frame SHALL discard the partial frame; the first transfer after deassertion is index 0.

Structure
REQ-027 A shared package net_pkg SHALL hold the state enum (COLLECT, DONE) and the WORD_SIZE default constant.
REQ-028 The signed greater-than and select logic SHALL be one combinational sub-module, max_compare (inputs: candidate, current max, index; outputs: update flag).
REQ-029 The implementation SHALL be synthesizable, with no latches and a single always_ff for all registers.

Verification (WORD_SIZE=16, NUM_CLASSES=4)
REQ-030 Stream 3,-2,7,1 with valid_i continuous and ready_i=1 -> four consecutive yumi_o pulses; valid_o high one cycle after the 4th, for exactly one cycle, with class_o=2, max_o=7, frame_cnt_o 0->1.
REQ-031 Ties: stream 5,5,-1,5 -> class_o=0, max_o=5.
REQ-032 All negative: stream -8,-3,-3,-9 -> class_o=1, max_o=-3 (0xFFFD).
REQ-033 Backpressure: ready_i=0 for 5 cycles after the result while valid_i=1 with the next frame's word 9 -> valid_o, class_o and max_o hold and yumi_o=0; after ready_i=1, word 9 is accepted as index 0 on the next cycle.
REQ-034 Reset mid-frame: send 4,6, pulse reset_i asynchronously between edges -> outputs are zero immediately; then send 1,2,3,4 -> class_o=3, max_o=4, frame_cnt_o=1.
REQ-035 Gaps: 0,10,0,0 with valid_i low for 2 cycles between each word -> exactly 4 transfers; class_o=1, max_o=10.

Source files
------------

// File: rtl/net_pkg.sv
// Shared definitions for the score-stream blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: frame collection state enum and the default score word width.
package net_pkg;

    localparam int WORD_SIZE_DEFAULT = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

endpackage

// File: rtl/class_argmax_if.sv
// Bundle of the score-in stream and the result-out handshake of class_argmax.
// Latency: n/a (wiring only).
// Backpressure: yumi is the consume strobe upstream; ready stalls the result.
//
// Signals: valid/data/yumi (score stream), res_valid/ready/cls/max/frame_cnt
// (frame result). master = score producer + result consumer, slave = argmax.
interface class_argmax_if #(
    parameter int WORD_SIZE = 16,
    parameter int CLASS_W   = 2
);
    logic                 valid;
    logic [WORD_SIZE-1:0] data;
    logic                 yumi;
    logic                 res_valid;
    logic                 ready;
    logic [CLASS_W-1:0]   cls;
    logic [WORD_SIZE-1:0] max;
    logic [15:0]          frame_cnt;

    modport master (
        output valid, data, ready,
        input  yumi, res_valid, cls, max, frame_cnt
    );

    modport slave (
        input  valid, data, ready,
        output yumi, res_valid, cls, max, frame_cnt
    );
endinterface

// File: rtl/max_compare.sv
// Decides whether an incoming score replaces the running maximum.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: candidate (incoming signed score), cur_max (running signed max),
// index (position of candidate in frame), update (1 = load candidate).
module max_compare
    import net_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
    parameter int CLASS_W   = 2
) (
    input  logic signed [WORD_SIZE-1:0] candidate,
    input  logic signed [WORD_SIZE-1:0] cur_max,
    input  logic        [CLASS_W-1:0]   index,
    output logic                        update
);
    // The first word of a frame always seeds the max; later words must be
    // strictly greater, so ties keep the earlier (lower) index.
    assign update = (index == '0) || (candidate > cur_max);
endmodule

// File: rtl/class_argmax.sv
// Streams NUM_CLASSES signed scores per frame and reports argmax + max value.
// Latency: result valid one cycle after the last word of a frame is consumed.
// Backpressure: result held until ready_i; no words are consumed meanwhile.
//
// Ports: clk_i, reset_i (async, active-high); valid_i/data_i/yumi_o score
// stream in; valid_o/ready_i result handshake; class_o, max_o result;
// frame_cnt_o count of result handshakes (wraps at 16 bits).
module class_argmax
    import net_pkg::*;
#(
    parameter int WORD_SIZE   = WORD_SIZE_DEFAULT,
    parameter int NUM_CLASSES = 4,
    parameter int CLASS_W     = $clog2(NUM_CLASSES)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        valid_i,
    input  logic signed [WORD_SIZE-1:0] data_i,
    output logic                        yumi_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic        [CLASS_W-1:0]   class_o,
    output logic signed [WORD_SIZE-1:0] max_o,
    output logic        [15:0]          frame_cnt_o
);
    localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

    state_t                      state_r, state_nxt;
    logic        [CLASS_W-1:0]   idx_r,   idx_nxt;
    logic        [CLASS_W-1:0]   class_r, class_nxt;
    logic signed [WORD_SIZE-1:0] max_r,   max_nxt;
    logic        [15:0]          cnt_r,   cnt_nxt;
    logic                        update;

    // Reset is folded in so nothing is reported as consumed while the block
    // is being cleared.
    assign yumi_o      = valid_i && (state_r == COLLECT) && !reset_i;
    assign valid_o     = (state_r == DONE);
    assign class_o     = class_r;
    assign max_o       = max_r;
    assign frame_cnt_o = cnt_r;

    max_compare #(
        .WORD_SIZE (WORD_SIZE),
        .CLASS_W   (CLASS_W)
    ) u_cmp (
        .candidate (data_i),
        .cur_max   (max_r),
        .index     (idx_r),
        .update    (update)
    );

    always_comb begin
        state_nxt = state_r;
        idx_nxt   = idx_r;
        class_nxt = class_r;
        max_nxt   = max_r;
        cnt_nxt   = cnt_r;
        case (state_r)
            COLLECT: begin
                if (yumi_o) begin
                    if (update) begin
                        max_nxt   = data_i;
                        class_nxt = idx_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        idx_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx_r + 1'b1;
                    end
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_nxt = COLLECT;
                    cnt_nxt   = cnt_r + 16'd1;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= COLLECT;
            idx_r   <= '0;
            class_r <= '0;
            max_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt;
            idx_r   <= idx_nxt;
            class_r <= class_nxt;
            max_r   <= max_nxt;
            cnt_r   <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_class_argmax.sv
// Self-checking bench for class_argmax (WORD_SIZE=16, NUM_CLASSES=4).
// Latency: n/a.
// Backpressure: exercised with held ready and randomised ready.
module tb_class_argmax;

    typedef logic [15:0] frame_t [4];

    typedef struct {
        logic [1:0]  cls;
        logic [15:0] mx;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    class_argmax_if #(.WORD_SIZE(16), .CLASS_W(2)) bus ();

    class_argmax #(
        .WORD_SIZE   (16),
        .NUM_CLASSES (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .valid_i     (bus.valid),
        .data_i      (bus.data),
        .yumi_o      (bus.yumi),
        .valid_o     (bus.res_valid),
        .ready_i     (bus.ready),
        .class_o     (bus.cls),
        .max_o       (bus.max),
        .frame_cnt_o (bus.frame_cnt)
    );

    exp_t        sb[$];
    int          n_chk    = 0;
    int          n_pass   = 0;
    int          xfer_cnt = 0;
    logic [15:0] exp_cnt  = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference argmax: first word seeds, later words win only if strictly greater.
    function automatic exp_t model(input frame_t f, input logic [15:0] cnt);
        exp_t e;
        e.cls = 2'd0;
        e.mx  = f[0];
        for (int i = 1; i < 4; i++) begin
            if ($signed(f[i]) > $signed(e.mx)) begin
                e.mx  = f[i];
                e.cls = 2'(i);
            end
        end
        e.cnt = cnt;
        return e;
    endfunction

    task automatic push_exp(input frame_t f);
        sb.push_back(model(f, exp_cnt));
        exp_cnt = exp_cnt + 16'd1;
    endtask

    // Sampled on the falling edge: counts transfers and scores each result handshake.
    task automatic monitor_step();
        exp_t e;
        if (!rst) begin
            if (bus.yumi) xfer_cnt++;
            if (bus.res_valid && bus.valid) chk("yumi_in_done", 32'(bus.yumi), 32'd0);
            if (bus.res_valid && bus.ready) begin
                chk("result_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("class", 32'(bus.cls), 32'(e.cls));
                    chk("max", 32'(bus.max), 32'(e.mx));
                    chk("frame_cnt", 32'(bus.frame_cnt), 32'(e.cnt));
                end
            end
        end
    endtask

    always @(negedge clk) monitor_step();

    // Presents one word and holds it until consumed; n = falling edges waited.
    task automatic send_word(input logic [15:0] w, output int n);
        n = 0;
        bus.valid = 1'b1;
        bus.data  = w;
        forever begin
            @(negedge clk);
            n++;
            if (bus.yumi || n >= 60) break;
            @(posedge clk);
            #1;
            bus.ready = 1'b1;
        end
        chk("yumi_seen", 32'(bus.yumi), 32'd1);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input int gap, input bit rnd);
        int n;
        int g;
        push_exp(f);
        for (int i = 0; i < 4; i++) begin
            if (rnd) bus.ready = 1'($urandom_range(0, 1));
            send_word(f[i], n);
            g = rnd ? int'($urandom_range(0, 2)) : gap;
            if (i < 3) begin
                for (int k = 0; k < g; k++) begin
                    @(posedge clk);
                    #1;
                    if (rnd) bus.ready = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.ready = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        frame_t f;
        int     n;
        int     xb;

        rst       = 1'b1;
        bus.valid = 1'b1;
        bus.data  = 16'h1234;
        bus.ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid_o", 32'(bus.res_valid), 32'd0);
        chk("rst_yumi", 32'(bus.yumi), 32'd0);
        chk("rst_class", 32'(bus.cls), 32'd0);
        chk("rst_max", 32'(bus.max), 32'd0);
        chk("rst_cnt", 32'(bus.frame_cnt), 32'd0);
        bus.valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Continuous stream: four back-to-back consumes, one-cycle result pulse.
        f = '{16'd3, 16'hFFFE, 16'd7, 16'd1};
        push_exp(f);
        for (int i = 0; i < 4; i++) begin
            send_word(f[i], n);
            chk("yumi_back_to_back", 32'(n), 32'd1);
        end
        @(negedge clk);
        chk("result_latency", 32'(bus.res_valid), 32'd1);
        chk("cnt_before_hs", 32'(bus.frame_cnt), 32'd0);
        @(negedge clk);
        chk("result_one_cycle", 32'(bus.res_valid), 32'd0);
        chk("cnt_after_hs", 32'(bus.frame_cnt), 32'd1);
        @(posedge clk);
        #1;

        // All negative scores.
        f = '{16'hFFF8, 16'hFFFD, 16'hFFFD, 16'hFFF7};
        send_frame(f, 0, 1'b0);
        drain();

        // Ties, then hold the result for five cycles while the next word waits.
        bus.ready = 1'b0;
        f = '{16'd5, 16'd5, 16'hFFFF, 16'd5};
        send_frame(f, 0, 1'b0);
        f = '{16'd9, 16'hFFFC, 16'd12, 16'd12};
        push_exp(f);
        bus.valid = 1'b1;
        bus.data  = 16'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", 32'(bus.res_valid), 32'd1);
            chk("bp_class_hold", 32'(bus.cls), 32'd0);
            chk("bp_max_hold", 32'(bus.max), 32'd5);
            chk("bp_yumi_low", 32'(bus.yumi), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.ready = 1'b1;
        @(negedge clk);
        chk("bp_yumi_at_hs", 32'(bus.yumi), 32'd0);
        @(negedge clk);
        chk("bp_valid_cleared", 32'(bus.res_valid), 32'd0);
        chk("bp_word_taken", 32'(bus.yumi), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 1; i < 4; i++) send_word(f[i], n);
        drain();

        // Idle gaps of two cycles between every word.
        xb = xfer_cnt;
        f = '{16'd0, 16'd10, 16'd0, 16'd0};
        send_frame(f, 2, 1'b0);
        drain();
        chk("gap_transfers", 32'(xfer_cnt - xb), 32'd4);

        // Random scores, gaps and downstream stalls.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 4; i++)
                f[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 4) - 2);
            send_frame(f, 0, 1'b1);
        end
        drain();

        // Asynchronous reset in the middle of a frame.
        send_word(16'd4, n);
        send_word(16'd6, n);
        #3;
        bus.valid = 1'b1;
        bus.data  = 16'd77;
        rst       = 1'b1;
        #1;
        chk("mid_rst_valid_o", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_yumi", 32'(bus.yumi), 32'd0);
        chk("mid_rst_class", 32'(bus.cls), 32'd0);
        chk("mid_rst_max", 32'(bus.max), 32'd0);
        chk("mid_rst_cnt", 32'(bus.frame_cnt), 32'd0);
        bus.valid = 1'b0;
        exp_cnt   = 16'd0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        f = '{16'd1, 16'd2, 16'd3, 16'd4};
        send_frame(f, 0, 1'b0);
        drain();
        @(negedge clk);
        chk("post_rst_cnt", 32'(bus.frame_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
